// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase sequencer: phase codes, lamp encodings and
// the cyclic phase successor.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } phase_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  function automatic phase_e next_phase(input phase_e p);
    unique case (p)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALL_RED_1;
      ALL_RED_1: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALL_RED_2;
      default:   return NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Request and lamp-drive bundle of the traffic phase sequencer.
// The sequencer sits on the slave side; stimulus or a controller on the master side.
interface traffic_phase_sequencer_if;

  logic       ped_req;
  logic       hold;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output ped_req, hold,
    input  ns_light, ew_light, walk, phase
  );

  modport slave (
    input  ped_req, hold,
    output ns_light, ew_light, walk, phase
  );

endinterface

// File: rtl/phase_timer.sv
// Down-counter holding the time left in the current phase; o_done flags zero.
// Reset is applied by the owner through a load of the reset length.
module phase_timer #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_value,
  input  logic                 i_enable,
  output logic                 o_done
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road phase controller: green/yellow/all-red sequencing with hold and an
// optional pedestrian walk service enabled by the TRAFFIC_PED_WALK_EN macro.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 2,
  parameter int unsigned WALK_CYCLES   = 6,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_phase_sequencer_if.slave   io_bus
);

  phase_e               r_phase;
  phase_e               w_next_phase;
  logic                 w_done;
  logic                 w_advance;
  logic                 w_load;
  logic [CNT_WIDTH-1:0] w_load_value;
  logic                 w_walk_next;
  logic                 w_walk;

  assign w_next_phase = next_phase(r_phase);
  assign w_advance    = !io_bus.hold && w_done;
  // Reset reloads the timer so the first all-red gets its full length.
  assign w_load       = rst || w_advance;

`ifdef TRAFFIC_PED_WALK_EN
  logic r_ped_pending;
  logic r_walk_active;

  assign w_walk_next = r_ped_pending &&
                       ((w_next_phase == ALL_RED_1) || (w_next_phase == ALL_RED_2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ped_pending <= 1'b0;
      r_walk_active <= 1'b0;
    end else begin
      // A new press on the servicing edge keeps the request alive.
      if (io_bus.ped_req) begin
        r_ped_pending <= 1'b1;
      end else if (w_advance && w_walk_next) begin
        r_ped_pending <= 1'b0;
      end
      if (w_advance) begin
        r_walk_active <= w_walk_next;
      end
    end
  end

  assign w_walk = r_walk_active;
`else
  logic w_unused_ped;

  assign w_unused_ped = io_bus.ped_req;
  assign w_walk_next  = 1'b0;
  assign w_walk       = 1'b0;
`endif

  always_comb begin
    w_load_value = CNT_WIDTH'(ALLRED_CYCLES - 1);
    if (!rst) begin
      unique case (w_next_phase)
        NS_GREEN, EW_GREEN:   w_load_value = CNT_WIDTH'(GREEN_CYCLES - 1);
        NS_YELLOW, EW_YELLOW: w_load_value = CNT_WIDTH'(YELLOW_CYCLES - 1);
        default: begin
          w_load_value = w_walk_next ? CNT_WIDTH'(WALK_CYCLES - 1)
                                     : CNT_WIDTH'(ALLRED_CYCLES - 1);
        end
      endcase
    end
  end

  phase_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase_timer (
    .clk          (clk),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_enable     (!io_bus.hold),
    .o_done       (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= ALL_RED_2;
    end else if (w_advance) begin
      r_phase <= w_next_phase;
    end
  end

  // Only one road can ever be non-red since each phase drives at most one lamp.
  always_comb begin
    io_bus.ns_light = LAMP_RED;
    io_bus.ew_light = LAMP_RED;
    unique case (r_phase)
      NS_GREEN:  io_bus.ns_light = LAMP_GREEN;
      NS_YELLOW: io_bus.ns_light = LAMP_YELLOW;
      EW_GREEN:  io_bus.ew_light = LAMP_GREEN;
      EW_YELLOW: io_bus.ew_light = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign io_bus.walk  = w_walk;
  assign io_bus.phase = r_phase;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with G=4, Y=2, R=1, W=3; covers the
// pedestrian cases when TRAFFIC_PED_WALK_EN is defined, the ped-ignored build otherwise.
module tb_traffic_phase_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  traffic_phase_sequencer_if bus_if ();

  traffic_phase_sequencer #(
    .GREEN_CYCLES  (4),
    .YELLOW_CYCLES (2),
    .ALLRED_CYCLES (1),
    .WALK_CYCLES   (3),
    .CNT_WIDTH     (8)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ns_exp(input int ph);
    case (ph)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_exp(input int ph);
    case (ph)
      3:       return 3'b001;
      4:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Check that phase ph is shown for len cycles with the given walk level.
  task automatic expect_phase(input string tag, input int ph, input int len, input logic w);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_p%0d_c%0d_phase", tag, ph, i), 32'(bus_if.phase), 32'(ph));
      check($sformatf("%s_p%0d_c%0d_ns", tag, ph, i), 32'(bus_if.ns_light), 32'(ns_exp(ph)));
      check($sformatf("%s_p%0d_c%0d_ew", tag, ph, i), 32'(bus_if.ew_light), 32'(ew_exp(ph)));
      check($sformatf("%s_p%0d_c%0d_walk", tag, ph, i), 32'(bus_if.walk), 32'(w));
      check($sformatf("%s_p%0d_c%0d_safe", tag, ph, i),
            32'((bus_if.ns_light != 3'b100) && (bus_if.ew_light != 3'b100)), 32'(0));
      step();
    end
  endtask

  task automatic expect_cycle(input string tag);
    expect_phase(tag, 0, 4, 1'b0);
    expect_phase(tag, 1, 2, 1'b0);
    expect_phase(tag, 2, 1, 1'b0);
    expect_phase(tag, 3, 4, 1'b0);
    expect_phase(tag, 4, 2, 1'b0);
    expect_phase(tag, 5, 1, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus_if.ped_req = 1'b0;
    bus_if.hold    = 1'b0;
    step();
    step();
    check("rst_ns", 32'(bus_if.ns_light), 32'h4);
    check("rst_ew", 32'(bus_if.ew_light), 32'h4);
    check("rst_walk", 32'(bus_if.walk), 32'h0);
    check("rst_phase", 32'(bus_if.phase), 32'd5);
    rst = 1'b0;
    step();

    // Free run: two full periods of 14 starting at the first NS_GREEN cycle.
    expect_cycle("free0");
    expect_cycle("free1");

`ifdef TRAFFIC_PED_WALK_EN
    // Single-cycle press in NS_GREEN is served in ALL_RED_1 only.
    check("ped_start_phase", 32'(bus_if.phase), 32'd0);
    bus_if.ped_req = 1'b1;
    step();
    bus_if.ped_req = 1'b0;
    expect_phase("ped", 0, 3, 1'b0);
    expect_phase("ped", 1, 2, 1'b0);
    expect_phase("ped", 2, 3, 1'b1);
    expect_phase("ped", 3, 4, 1'b0);
    expect_phase("ped", 4, 2, 1'b0);
    expect_phase("ped", 5, 1, 1'b0);

    // Press held through the ALL_RED_1 entry edge: both all-reds walk.
    bus_if.ped_req = 1'b1;
    expect_phase("setw", 0, 4, 1'b0);
    expect_phase("setw", 1, 2, 1'b0);
    bus_if.ped_req = 1'b0;
    expect_phase("setw", 2, 3, 1'b1);
    expect_phase("setw", 3, 4, 1'b0);
    expect_phase("setw", 4, 2, 1'b0);
    expect_phase("setw", 5, 3, 1'b1);
`else
    // Button held the whole time has no effect.
    bus_if.ped_req = 1'b1;
    expect_cycle("noped0");
    expect_cycle("noped1");
    bus_if.ped_req = 1'b0;
`endif

    // Hold for 5 cycles from the first NS_YELLOW cycle: yellow lasts 7.
    expect_phase("hold", 0, 4, 1'b0);
    bus_if.hold = 1'b1;
    expect_phase("hold_on", 1, 5, 1'b0);
    bus_if.hold = 1'b0;
    expect_phase("hold_off", 1, 2, 1'b0);
    expect_phase("hold", 2, 1, 1'b0);

    // Reset in EW_GREEN while frozen, with a request pending in the walk build.
    check("mid_phase_pre", 32'(bus_if.phase), 32'd3);
`ifdef TRAFFIC_PED_WALK_EN
    bus_if.ped_req = 1'b1;
`endif
    step();
    bus_if.ped_req = 1'b0;
    check("mid_phase_pre2", 32'(bus_if.phase), 32'd3);
    rst         = 1'b1;
    bus_if.hold = 1'b1;
    step();
    rst         = 1'b0;
    bus_if.hold = 1'b0;
    check("mid_rst_phase", 32'(bus_if.phase), 32'd5);
    check("mid_rst_ns", 32'(bus_if.ns_light), 32'h4);
    check("mid_rst_ew", 32'(bus_if.ew_light), 32'h4);
    check("mid_rst_walk", 32'(bus_if.walk), 32'h0);
    expect_phase("mid", 5, 1, 1'b0);
    expect_cycle("mid");
    check("end_phase", 32'(bus_if.phase), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
